// File: rtl/rv_axi_read_responder_if.sv
// AXI4 read-address and read-data channel bundles used by the read responder.
// Modport "in" is the receiving (slave) side of a channel, "out" the sending side.
interface rv_axi_ar_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  lock;
  logic [3:0]            cache;
  logic [2:0]            prot;
  logic [3:0]            qos;
  logic [USER_WIDTH-1:0] user;

  modport in  (input valid, id, addr, len, size, burst, lock, cache, prot, qos, user,
               output ready);
  modport out (output valid, id, addr, len, size, burst, lock, cache, prot, qos, user,
               input ready);
endinterface

interface rv_axi_r_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;
  logic                  last;

  modport out (output valid, id, data, resp, last, input ready);
  modport in  (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rv_axi_read_responder.sv
// AXI4 read responder: serves one FIXED/INCR/WRAP burst at a time from a
// single-port synchronous memory with 1-cycle read latency.
module rv_axi_read_responder #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 1,
  parameter  int MEM_WORDS  = 1024,
  localparam int MEM_AW     = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_axi_ar_intf.in             ar,
  rv_axi_r_intf.out             r,
  output logic                  mem_read_enable,
  output logic [MEM_AW-1:0]     mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int WA    = ADDR_WIDTH - SZ;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_UNDEF = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_nx;
  logic                    arready_p0;
  logic [8:0]              cnt_p0;
  logic [ID_WIDTH-1:0]     id_p0;
  logic [7:0]              len_p0;
  logic [1:0]              burst_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic                    slv_p0;
  logic                    issue_p0;
  logic                    ar_hs;
  logic                    ar_bad;
  logic [WA-1:0]           word_p0;
  logic [1:0]              resp_p0;

  logic                    vld_p1;
  logic                    last_p1;
  logic [1:0]              resp_p1;
  logic [ID_WIDTH-1:0]     id_p1;
  logic                    err_p1;

  logic                    unused_ar;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            burst,
    input logic [7:0]            len
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = a + ADDR_WIDTH'(BYTES);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << SZ) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

  assign unused_ar = ^{ar.lock, ar.cache, ar.prot, ar.qos, ar.user};

  assign ar_hs    = ar.valid && arready_p0;
  assign ar.ready = arready_p0;

  // Any of these poisons the whole burst; WRAP only needs transfer-size alignment.
  assign ar_bad = (ar.size != 3'(SZ)) ||
                  (ar.burst == BURST_UNDEF) ||
                  ((ar.burst == BURST_WRAP) &&
                   !((ar.len == 8'd1) || (ar.len == 8'd3) ||
                     (ar.len == 8'd7) || (ar.len == 8'd15))) ||
                  ((ar.burst == BURST_WRAP) &&
                   ((ar.addr & ADDR_WIDTH'(BYTES - 1)) != '0));

  assign word_p0 = addr_p0[ADDR_WIDTH-1:SZ];
  assign resp_p0 = slv_p0                   ? RESP_SLVERR :
                   (word_p0 >= WA'(MEM_WORDS)) ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    state_nx = state;
    issue_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) state_nx = BURST;
      end
      BURST: begin
        issue_p0 = (cnt_p0 <= {1'b0, len_p0}) && (!vld_p1 || r.ready);
        if (vld_p1 && r.ready && last_p1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_read_enable = issue_p0 && (resp_p0 == RESP_OKAY);
  assign mem_read_addr   = word_p0[MEM_AW-1:0];

  // p0: request capture and beat issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      arready_p0 <= 1'b0;
      cnt_p0     <= '0;
    end else begin
      state      <= state_nx;
      arready_p0 <= (state_nx == IDLE);
      if (ar_hs)         cnt_p0 <= '0;
      else if (issue_p0) cnt_p0 <= cnt_p0 + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      id_p0    <= ar.id;
      len_p0   <= ar.len;
      burst_p0 <= ar.burst;
      addr_p0  <= ar.addr;
      slv_p0   <= ar_bad;
    end else if (issue_p0) begin
      addr_p0  <= next_addr(addr_p0, burst_p0, len_p0);
    end
  end

  // p1: R channel output register; data comes straight from the memory,
  // which holds its output while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      resp_p1 <= RESP_OKAY;
      id_p1   <= '0;
      err_p1  <= 1'b0;
    end else if (issue_p0) begin
      vld_p1  <= 1'b1;
      last_p1 <= (cnt_p0 == {1'b0, len_p0});
      resp_p1 <= resp_p0;
      id_p1   <= id_p0;
      err_p1  <= (resp_p0 != RESP_OKAY);
    end else if (r.ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign r.valid = vld_p1;
  assign r.last  = last_p1;
  assign r.resp  = resp_p1;
  assign r.id    = id_p1;
  assign r.data  = err_p1 ? '0 : mem_read_data;

endmodule

// File: doc/rv_axi_read_responder.md
# rv_axi_read_responder

AXI4 read-channel responder (slave end): accepts read-address requests on an `rv_axi_ar_intf.in` port and returns burst data on an `rv_axi_r_intf.out` port, sourced from a single-port synchronous memory with 1-cycle read latency. It sits in front of on-chip RAM/ROM so that AXI initiators such as fetch units, DMA and interconnect masters can read it. It handles FIXED, INCR and WRAP bursts and reports protocol and range errors in RRESP. It serves one outstanding burst at a time.

## Interface
- ADDR_WIDTH, 32, AXI byte-address width
- DATA_WIDTH, 32, R data width; power of two, ≥8
- ID_WIDTH, 1, ARID/RID width
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words; word index width MEM_AW = $clog2(MEM_WORDS)
- clk  input  1  sole clock; all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- ar  rv_axi_ar_intf.in  —  read address channel (ADDR_WIDTH, USER_WIDTH 1, ID_WIDTH)
- r  rv_axi_r_intf.out  —  read data channel (DATA_WIDTH, ID_WIDTH)
- mem_read_enable  output  1  memory read strobe
- mem_read_addr  output  MEM_AW  word index
- mem_read_data  input  DATA_WIDTH  valid the cycle after an enable; held while enable is low

## Operation
- States: IDLE, BURST.
- IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ARID, ARLEN, ARBURST and ARADDR; check for errors; set beats=ARLEN+1; go to BURST with ARREADY=0 next cycle. ARUSER, ARCACHE, ARLOCK, ARPROT and ARQOS are ignored.
- Error checks. Each check flags the whole burst with SLVERR:
  - ARSIZE ≠ log2(DATA_WIDTH/8)
  - ARBURST = UNDEF
  - ARBURST = WRAP with ARLEN ∉ {1,3,7,15}
  - ARADDR not size-aligned for WRAP
- Per-beat check: word index = addr >> log2(DATA_WIDTH/8). An index ≥ MEM_WORDS gives DECERR for that beat. SLVERR takes precedence over DECERR.
- Issue rule: a beat is issued in a cycle where state=BURST, issued<beats, and (!RVALID || RREADY).
  - OKAY beat: mem_read_enable=1 with the beat's index.
  - Error beat: no memory access.
- Output register:
  - RVALID is registered, set the cycle after an issue.
  - RDATA = mem_read_data for OKAY beats, 0 for error beats.
  - RRESP, RID and RLAST are registered alongside RVALID.
  - RLAST=1 on beat index ARLEN.
- Address update after each issued beat, with bytes = DATA_WIDTH/8:
  - FIXED: unchanged.
  - INCR: addr+bytes, modulo 2^ADDR_WIDTH.
  - WRAP: mask=(ARLEN+1)*bytes-1; addr=(addr&~mask)|((addr+bytes)&mask).
  - No 4 KB boundary checking.
- Completion: on the handshake with RLAST=1, go to IDLE. ARREADY=1 the following cycle.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=OKAY, RID=0, RDATA undefined, mem_read_enable=0, state IDLE. ARREADY rises on the first clk edge after rst deasserts.
- Latency: AR handshake at cycle N → first mem_read_enable at N+1 → RVALID at N+2.
- Throughput is 1 beat/cycle while RREADY=1.
- Turnaround: at least 1 idle cycle between a last-beat handshake and the next AR handshake.
- Backpressure: while RVALID&&!RREADY, all R outputs hold and no new read is issued. RDATA holds because the memory holds its output. RVALID never drops without a handshake.
- ARLEN=0: one beat with RLAST=1.
- ARVALID is ignored during BURST; a pending request waits.
- Reset mid-burst aborts immediately: outputs return to reset values and no further beats are produced.

## Test plan
- Single beat: ARADDR=0x10, ARLEN=0, INCR, ARID=1, mem[4]=0xA5A5_0004, RREADY=1 → one beat with RDATA=0xA5A5_0004, RLAST=1, RRESP=OKAY, RID=1; RVALID 2 cycles after the AR handshake.
- INCR len 3 at 0x00, RREADY=1 → 4 consecutive cycles reading mem[0..3]; RLAST on the 4th beat only.
- Backpressure on INCR len 3: hold RREADY low for 3 cycles on beat 1 → beat 1 data stable throughout, no beat lost or duplicated, mem_read_enable low while stalled.
- WRAP len 3 at 0x08 → word order 2,3,0,1. FIXED len 2 at 0x04 → word 1 three times.
- Errors:
  - ARSIZE=1 with 32-bit data, len 1 → 2 beats with SLVERR, RDATA=0, no memory reads.
  - MEM_WORDS=1024, INCR at 0xFFC, len 1 → beat 0 OKAY from mem[1023], beat 1 DECERR.
- Reset asserted on beat 2 of an 8-beat burst → RVALID=0 and ARREADY=0 immediately. After release, a new len-0 read completes normally with the correct RID.
